// File: rtl/set_assoc_cache.sv
// 2-way set-associative, write-through, no-write-allocate cache with LRU replacement
// and a pipelined block-fill engine (one word request issued per cycle, returns counted separately).
module set_assoc_cache #(
    parameter int unsigned ADDR_W        = 16,
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned NUM_SETS      = 64,
    parameter int unsigned WORDS_PER_BLK = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_rd,
    input  logic              pipe_wr,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0] pipe_wdata,
    output logic [DATA_W-1:0] pipe_rdata,
    output logic              stall,
    output logic              hit,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data
);

    localparam int unsigned INDEX_W = $clog2(NUM_SETS);
    localparam int unsigned WOFF_W  = $clog2(WORDS_PER_BLK);
    localparam int unsigned OFF_W   = WOFF_W + 1;
    localparam int unsigned TAG_W   = ADDR_W - INDEX_W - OFF_W;
    localparam int unsigned CNT_W   = WOFF_W + 1;
    localparam int unsigned LINE_W  = INDEX_W + WOFF_W;

    localparam logic [CNT_W-1:0] BLK_WORDS = CNT_W'(WORDS_PER_BLK);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_BLK - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_e;

    logic [DATA_W-1:0]   data_q  [2][NUM_SETS*WORDS_PER_BLK];
    logic [TAG_W-1:0]    tag_q   [2][NUM_SETS];
    logic [NUM_SETS-1:0] valid_q [2];
    logic [NUM_SETS-1:0] lru_q;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]   recv_cnt_q, recv_cnt_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic               victim_q, victim_d;

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_idx;
    logic [WOFF_W-1:0]  req_word;
    logic [INDEX_W-1:0] fill_idx;
    logic [1:0]         way_hit;
    logic               hit_way;
    logic               is_rd;
    logic               is_wr;
    logic               idle;
    logic               miss_start;
    logic               fill_we;
    logic               fill_done;
    logic               victim_sel;
    logic               unused_addr_lsb;

    assign req_tag         = pipe_addr[ADDR_W-1 -: TAG_W];
    assign req_idx         = pipe_addr[OFF_W +: INDEX_W];
    assign req_word        = pipe_addr[1 +: WOFF_W];
    assign unused_addr_lsb = pipe_addr[0];
    assign fill_idx        = base_q[OFF_W +: INDEX_W];

    always_comb begin
        for (int unsigned w = 0; w < 2; w++) begin
            way_hit[w] = valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag);
        end
    end

    // A write takes precedence when both request lines are raised.
    assign is_wr   = pipe_wr;
    assign is_rd   = pipe_rd && !pipe_wr;
    assign hit_way = way_hit[1];
    assign hit     = (pipe_rd || pipe_wr) && (|way_hit);
    assign idle    = (state_q == S_IDLE);

    assign pipe_rdata  = (is_rd && hit) ? data_q[hit_way][{req_idx, req_word}] : '0;
    assign stall       = !idle || (is_rd && !hit);
    assign mem_wr      = is_wr && idle;
    assign mem_wr_addr = pipe_addr;
    assign mem_wr_data = pipe_wdata;
    assign mem_rd      = !idle && (issue_cnt_q < BLK_WORDS);
    assign mem_rd_addr = base_q + (ADDR_W'(issue_cnt_q) << 1);

    assign miss_start = idle && is_rd && !hit;
    assign fill_we    = !idle && mem_valid;
    assign fill_done  = fill_we && (recv_cnt_q == LAST_WORD);

    always_comb begin
        if (!valid_q[0][req_idx]) begin
            victim_sel = 1'b0;
        end else if (!valid_q[1][req_idx]) begin
            victim_sel = 1'b1;
        end else begin
            victim_sel = lru_q[req_idx];
        end
    end

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        base_d      = base_q;
        victim_d    = victim_q;
        case (state_q)
            S_IDLE: begin
                if (miss_start) begin
                    state_d     = S_FILL;
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                    base_d      = {req_tag, req_idx, {OFF_W{1'b0}}};
                    victim_d    = victim_sel;
                end
            end
            S_FILL: begin
                if (mem_rd) begin
                    issue_cnt_d = issue_cnt_q + CNT_W'(1);
                end
                if (mem_valid) begin
                    recv_cnt_d = recv_cnt_q + CNT_W'(1);
                end
                if (fill_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The victim is invalidated as the fill starts, so its old tag can never
    // match a half-overwritten line if the fill is cut short by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            base_q      <= '0;
            victim_q    <= 1'b0;
            valid_q[0]  <= '0;
            valid_q[1]  <= '0;
            lru_q       <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            base_q      <= base_d;
            victim_q    <= victim_d;
            if (miss_start) begin
                valid_q[victim_sel][req_idx] <= 1'b0;
            end
            if (fill_done) begin
                valid_q[victim_q][fill_idx] <= 1'b1;
                lru_q[fill_idx]             <= ~victim_q;
            end
            if (idle && hit) begin
                lru_q[req_idx] <= ~hit_way;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_q[victim_q][{fill_idx, recv_cnt_q[WOFF_W-1:0]}] <= mem_rdata;
        end else if (idle && is_wr && hit) begin
            data_q[hit_way][{req_idx, req_word}] <= pipe_wdata;
        end
        if (fill_done) begin
            tag_q[victim_q][fill_idx] <= base_q[ADDR_W-1 -: TAG_W];
        end
    end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Scoreboard bench for set_assoc_cache: a tag-recency reference model and a backing memory
// predict fills, write-throughs and read data; a negedge monitor pops and compares.
module tb_set_assoc_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_rd, pipe_wr;
    logic [15:0] pipe_addr, pipe_wdata, pipe_rdata;
    logic        stall, hit, mem_rd;
    logic [15:0] mem_rd_addr;
    logic        mem_valid;
    logic [15:0] mem_rdata;
    logic        mem_wr;
    logic [15:0] mem_wr_addr, mem_wr_data;

    set_assoc_cache #(
        .ADDR_W(16),
        .DATA_W(16),
        .NUM_SETS(64),
        .WORDS_PER_BLK(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pipe_rd(pipe_rd),
        .pipe_wr(pipe_wr),
        .pipe_addr(pipe_addr),
        .pipe_wdata(pipe_wdata),
        .pipe_rdata(pipe_rdata),
        .stall(stall),
        .hit(hit),
        .mem_rd(mem_rd),
        .mem_rd_addr(mem_rd_addr),
        .mem_valid(mem_valid),
        .mem_rdata(mem_rdata),
        .mem_wr(mem_wr),
        .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: observed 0x%0h with nothing expected (t=%0t)", name, act, $time);
    endtask

    // Backing memory, word addressed; writes go straight through to it.
    logic [15:0] mem_model [32768];

    // Reference cache: per set, the resident tags ordered most-recent first.
    int unsigned occ  [64];
    logic [5:0]  rec0 [64];
    logic [5:0]  rec1 [64];

    function automatic bit model_hit(input logic [5:0] s, input logic [5:0] t);
        return (occ[s] >= 1 && rec0[s] == t) || (occ[s] == 2 && rec1[s] == t);
    endfunction

    function automatic void model_touch(input logic [5:0] s, input logic [5:0] t);
        if (occ[s] == 2 && rec1[s] == t) begin
            rec1[s] = rec0[s];
            rec0[s] = t;
        end
    endfunction

    function automatic void model_fill(input logic [5:0] s, input logic [5:0] t);
        if (occ[s] >= 1) begin
            rec1[s] = rec0[s];
            occ[s]  = 2;
        end else begin
            occ[s] = 1;
        end
        rec0[s] = t;
    endfunction

    function automatic void model_clear();
        for (int unsigned i = 0; i < 64; i++) occ[i] = 0;
    endfunction

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } rd_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
        logic        hit;
    } wr_t;

    logic [15:0] exp_fill_q [$];
    rd_t         exp_rd_q   [$];
    wr_t         exp_wr_q   [$];

    int unsigned issued_cnt   = 0;
    int unsigned returned_cnt = 0;

    // Memory responder: in-order returns with a selectable gap, optional stray pulses when idle.
    logic [15:0] pend_q [$];
    int unsigned gap_mode    = 0;
    bit          spurious_en = 1'b0;
    int unsigned gap_left    = 0;
    logic        mem_real    = 1'b0;

    function automatic int unsigned next_gap();
        case (gap_mode)
            0:       return 0;
            1:       return 1;
            2:       return 4;
            default: return $urandom_range(0, 4);
        endcase
    endfunction

    always @(negedge clk) begin
        logic [15:0] ra;
        if (mem_rd === 1'b1) pend_q.push_back(mem_rd_addr);
        if (pend_q.size() != 0 && gap_left == 0) begin
            ra        = pend_q.pop_front();
            mem_valid = 1'b1;
            mem_real  = 1'b1;
            mem_rdata = mem_model[ra[15:1]];
            gap_left  = next_gap();
        end else begin
            if (gap_left != 0) gap_left--;
            mem_real  = 1'b0;
            mem_valid = (pend_q.size() == 0) && spurious_en && ($urandom_range(0, 3) == 0);
            mem_rdata = 16'($urandom);
        end
    end

    always @(posedge clk) begin
        if (mem_valid && mem_real) returned_cnt++;
    end

    // Monitor
    always @(negedge clk) begin
        logic [15:0] ea;
        rd_t r;
        wr_t w;
        if (rst === 1'b0) begin
            if (mem_rd === 1'b1) begin
                issued_cnt++;
                if (exp_fill_q.size() == 0) begin
                    fail_now("unexpected_mem_rd", 32'(mem_rd_addr));
                end else begin
                    ea = exp_fill_q.pop_front();
                    check("mem_rd_addr", 32'(mem_rd_addr), 32'(ea));
                end
            end
            if (mem_wr === 1'b1) begin
                if (exp_wr_q.size() == 0) begin
                    fail_now("unexpected_mem_wr", 32'(mem_wr_addr));
                end else begin
                    w = exp_wr_q.pop_front();
                    check("mem_wr_addr", 32'(mem_wr_addr), 32'(w.addr));
                    check("mem_wr_data", 32'(mem_wr_data), 32'(w.data));
                    check("wr_hit", 32'(hit), 32'(w.hit));
                    check("wr_stall", 32'(stall), 32'(0));
                end
            end
            if (pipe_rd === 1'b1 && pipe_wr === 1'b0 && stall === 1'b0) begin
                if (exp_rd_q.size() == 0) begin
                    fail_now("unexpected_read_done", 32'(pipe_addr));
                end else begin
                    r = exp_rd_q.pop_front();
                    check("rd_data", 32'(pipe_rdata), 32'(r.data));
                    check("rd_hit", 32'(hit), 32'(1));
                    check("fill_addrs_left", 32'(exp_fill_q.size()), 32'(0));
                    check("words_outstanding", 32'(issued_cnt - returned_cnt), 32'(0));
                end
            end
        end
    end

    task automatic apply_reset(input bit chk);
        @(posedge clk);
        #1;
        rst     = 1'b1;
        pipe_rd = 1'b0;
        pipe_wr = 1'b0;
        exp_fill_q.delete();
        exp_rd_q.delete();
        exp_wr_q.delete();
        model_clear();
        #1;
        if (chk) begin
            check("rst_stall", 32'(stall), 32'(0));
            check("rst_mem_rd", 32'(mem_rd), 32'(0));
            check("rst_hit", 32'(hit), 32'(0));
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic start_read(input logic [15:0] a);
        rd_t r;
        @(posedge clk);
        #1;
        if (!model_hit(a[9:4], a[15:10])) begin
            for (int unsigned i = 0; i < 8; i++) exp_fill_q.push_back({a[15:4], 4'h0} + 16'(2 * i));
            model_fill(a[9:4], a[15:10]);
        end else begin
            model_touch(a[9:4], a[15:10]);
        end
        r.addr = a;
        r.data = mem_model[a[15:1]];
        exp_rd_q.push_back(r);
        pipe_rd    = 1'b1;
        pipe_wr    = 1'b0;
        pipe_addr  = a;
        pipe_wdata = 16'($urandom);
    endtask

    task automatic wait_read();
        bit done = 1'b0;
        for (int unsigned k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            if (stall === 1'b0) done = 1'b1;
        end
        if (!done) begin
            fail_now("read_timeout", 32'(pipe_addr));
            apply_reset(1'b0);
            repeat (60) @(posedge clk);
        end
    endtask

    task automatic do_read(input logic [15:0] a);
        start_read(a);
        wait_read();
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d, input bit both);
        wr_t w;
        @(posedge clk);
        #1;
        w.hit = model_hit(a[9:4], a[15:10]);
        if (w.hit) model_touch(a[9:4], a[15:10]);
        mem_model[a[15:1]] = d;
        w.addr = a;
        w.data = d;
        exp_wr_q.push_back(w);
        pipe_wr    = 1'b1;
        pipe_rd    = both;
        pipe_addr  = a;
        pipe_wdata = d;
        @(negedge clk);
    endtask

    task automatic do_idle(input int unsigned n);
        @(posedge clk);
        #1;
        pipe_rd = 1'b0;
        pipe_wr = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned r0;
        bit got;
        logic [15:0] a;
        rst        = 1'b1;
        pipe_rd    = 1'b0;
        pipe_wr    = 1'b0;
        pipe_addr  = '0;
        pipe_wdata = '0;
        mem_valid  = 1'b0;
        mem_rdata  = '0;
        for (int unsigned i = 0; i < 32768; i++) mem_model[i] = 16'($urandom);
        model_clear();

        repeat (3) @(posedge clk);
        #1;
        check("reset_stall", 32'(stall), 32'(0));
        check("reset_hit", 32'(hit), 32'(0));
        check("reset_mem_rd", 32'(mem_rd), 32'(0));
        check("reset_mem_wr", 32'(mem_wr), 32'(0));
        check("reset_rdata", 32'(pipe_rdata), 32'(0));
        rst = 1'b0;

        // Cold miss on 0x0046: fill of 0x0040..0x004E, then the word at offset 3.
        gap_mode = 0;
        do_read(16'h0046);
        // Same-set second block goes to the other way; both then hit.
        do_read(16'h0040);
        do_read(16'h0440);
        do_read(16'h0040);
        do_read(16'h0442);
        // LRU eviction: 0x0840 replaces 0x0440.
        do_read(16'h0040);
        do_read(16'h0840);
        do_read(16'h0040);
        do_read(16'h0440);
        // Write hit then read back; write miss allocates nothing.
        do_write(16'h0042, 16'hBEEF, 1'b0);
        do_read(16'h0042);
        do_write(16'h1000, 16'h1234, 1'b1);
        do_read(16'h1000);

        // Return gaps of 0, 1 and 4 cycles, then read every word of each block.
        for (int unsigned g = 0; g < 3; g++) begin
            gap_mode = g;
            a = 16'h0C00 | 16'((10 + g) << 4);
            do_read(a);
            for (int unsigned wd = 0; wd < 8; wd++) do_read(a + 16'(2 * wd));
        end

        // Reset after three returned words: the partial block must not survive.
        gap_mode = 2;
        spurious_en = 1'b0;
        start_read(16'h2A36);
        r0  = returned_cnt;
        got = 1'b0;
        for (int unsigned k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (returned_cnt - r0 >= 3) got = 1'b1;
        end
        check("three_words_returned", 32'(got), 32'(1));
        apply_reset(1'b1);
        repeat (60) @(posedge clk);
        gap_mode = 0;
        do_read(16'h2A36);
        do_read(16'h2A30);

        // Randomised mix over a few sets and tags to exercise hits, misses and evictions.
        for (int unsigned n = 0; n < 400; n++) begin
            logic [5:0] tg;
            case ($urandom_range(0, 3))
                0: tg = 6'd0;
                1: tg = 6'd1;
                2: tg = 6'd2;
                default: tg = 6'd5;
            endcase
            a = {tg, 6'($urandom_range(0, 3)), 4'($urandom)};
            gap_mode    = $urandom_range(0, 3);
            spurious_en = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 9))
                0, 1, 2: do_write(a, 16'($urandom), ($urandom_range(0, 1) == 1));
                3:       do_idle($urandom_range(0, 3));
                default: do_read(a);
            endcase
        end

        do_idle(60);
        check("end_fill_queue", 32'(exp_fill_q.size()), 32'(0));
        check("end_read_queue", 32'(exp_rd_q.size()), 32'(0));
        check("end_write_queue", 32'(exp_wr_q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
